// File: rtl/cmap_pkg.sv
// cmap_pkg: shared stage encoding, colour struct and the 8-bit colour constants
// used by layer_color_mapper and cmap_fade_ctrl.
package cmap_pkg;

    typedef enum logic [1:0] {
        START  = 2'd0,
        BATTLE = 2'd1,
        WIN    = 2'd2,
        LOSE   = 2'd3
    } stage_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t TEXT_RGB    = 24'h000000;
    localparam rgb_t BG_START    = 24'h0000FF;
    localparam rgb_t BG_WIN      = 24'h9C1D08;
    localparam rgb_t BG_LOSE     = 24'h57007F;
    localparam rgb_t BG_PLATFORM = 24'h00FF00;
    // Battle sky base colour; blue is reduced by DrawX/8 across the line.
    localparam rgb_t BG_BATTLE   = 24'h3F007F;

endpackage

// File: rtl/cmap_fade_ctrl.sv
// cmap_fade_ctrl: stage tracking and frame-stepped fade level for the colour mapper.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   frame_start  one-cycle pulse per frame; the only moment level/stage_cur move
//   stage_req    requested stage
//   level        fade level 0..2**FADE_W (only with CMAP_FADE_EN)
//   busy         fade sequence in progress
//   stage_cur    stage currently being drawn
// Configuration: CMAP_FADE_EN selects the fade FSM; otherwise stage_cur simply
// follows stage_req at each frame_start.
module cmap_fade_ctrl
    import cmap_pkg::*;
`ifdef CMAP_FADE_EN
#(
    parameter int FADE_W = 4
)
`endif
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  stage_t           stage_req,
`ifdef CMAP_FADE_EN
    output logic [FADE_W:0]  level,
`endif
    output logic             busy,
    output stage_t           stage_cur
);

`ifdef CMAP_FADE_EN
    localparam logic [FADE_W:0] FULL = {1'b1, {FADE_W{1'b0}}};
    localparam logic [FADE_W:0] ONE  = {{FADE_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} fstate_t;

    fstate_t         state, state_nx;
    stage_t          pending, pending_nx, cur_nx;
    logic [FADE_W:0] level_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= START;
            stage_cur <= START;
            level     <= FULL;
        end else begin
            state     <= state_nx;
            pending   <= pending_nx;
            stage_cur <= cur_nx;
            level     <= level_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        cur_nx     = stage_cur;
        level_nx   = level;
        case (state)
            IDLE: begin
                if (stage_req != stage_cur) begin
                    pending_nx = stage_req;
                    state_nx   = FADE_OUT;
                end
            end
            FADE_OUT: begin
                // pending tracks the request, even if it returns to stage_cur
                pending_nx = stage_req;
                if (frame_start) begin
                    if (level <= ONE) begin
                        level_nx = '0;
                        cur_nx   = pending_nx;
                        state_nx = FADE_IN;
                    end else begin
                        level_nx = level - ONE;
                    end
                end
            end
            FADE_IN: begin
                if (stage_req != stage_cur) begin
                    pending_nx = stage_req;
                    state_nx   = FADE_OUT;
                end else if (frame_start) begin
                    level_nx = level + ONE;
                    if (level_nx == FULL) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_cur <= START;
        else if (frame_start) stage_cur <= stage_req;
    end

    assign busy = 1'b0;
`endif

endmodule

// File: rtl/layer_color_mapper.sv
// layer_color_mapper: two-stage pixel colour mapper (select, then fade scale).
// Ports:
//   Clk, Reset_n          pixel clock, asynchronous active-low reset
//   pix_valid             pixel inputs valid this cycle
//   DrawX, DrawY          current pixel position
//   layer_hit, layer_rgb  per-layer hit flags and R,G,B colours (layer 0 highest)
//   text_hit              lit font bit of the active word
//   stage_req             requested stage
//   frame_start           one-cycle pulse per frame
//   VGA_R/G/B, out_valid  registered colour and matching valid, 2 cycles latency
//   fade_busy, stage_cur  fade status and stage being drawn
// Configuration: CMAP_FADE_EN enables the fade FSM and the per-channel scale;
// without it the scale stage is a plain register.
module layer_color_mapper
    import cmap_pkg::*;
#(
    parameter int NUM_LAYERS = 3,
    parameter int COLOR_W    = 8,
    parameter int FADE_W     = 4,
    parameter int PLATFORM_Y = 380
)(
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          pix_valid,
    input  logic [9:0]                    DrawX,
    input  logic [9:0]                    DrawY,
    input  logic [NUM_LAYERS-1:0]         layer_hit,
    input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb,
    input  logic                          text_hit,
    input  stage_t                        stage_req,
    input  logic                          frame_start,
    output logic [COLOR_W-1:0]            VGA_R,
    output logic [COLOR_W-1:0]            VGA_G,
    output logic [COLOR_W-1:0]            VGA_B,
    output logic                          out_valid,
    output logic                          fade_busy,
    output stage_t                        stage_cur
);

    localparam int         CW3    = 3 * COLOR_W;
    localparam logic [9:0] PLAT_Y = 10'(PLATFORM_Y);

    // Resize an 8-bit package constant to COLOR_W, keeping its MSBs.
    function automatic logic [COLOR_W-1:0] fit8(logic [7:0] v);
        return COLOR_W'({v, {COLOR_W{1'b0}}} >> 8);
    endfunction

    function automatic logic [CW3-1:0] fit(rgb_t c);
        return {fit8(c.r), fit8(c.g), fit8(c.b)};
    endfunction

    rgb_t           bat_rgb, bg;
    logic [CW3-1:0] lay, sel, s1_rgb, s2_rgb;
    logic           s1_valid;

`ifdef CMAP_FADE_EN
    logic [FADE_W:0] level;

    // Full-width product so level = 2**FADE_W returns c unchanged.
    function automatic logic [COLOR_W-1:0] scale(logic [COLOR_W-1:0] c, logic [FADE_W:0] lv);
        logic [COLOR_W+FADE_W:0] p;
        p = {{(FADE_W+1){1'b0}}, c} * {{COLOR_W{1'b0}}, lv};
        return COLOR_W'(p >> FADE_W);
    endfunction

    cmap_fade_ctrl #(.FADE_W(FADE_W)) u_fade (
        .clk         (Clk),
        .rst_n       (Reset_n),
        .frame_start (frame_start),
        .stage_req   (stage_req),
        .level       (level),
        .busy        (fade_busy),
        .stage_cur   (stage_cur)
    );

    assign s2_rgb = {scale(s1_rgb[2*COLOR_W +: COLOR_W], level),
                     scale(s1_rgb[COLOR_W +: COLOR_W], level),
                     scale(s1_rgb[0 +: COLOR_W], level)};
`else
    cmap_fade_ctrl u_fade (
        .clk         (Clk),
        .rst_n       (Reset_n),
        .frame_start (frame_start),
        .stage_req   (stage_req),
        .busy        (fade_busy),
        .stage_cur   (stage_cur)
    );

    assign s2_rgb = s1_rgb;
`endif

    always_comb begin
        bat_rgb = {BG_BATTLE.r, BG_BATTLE.g, BG_BATTLE.b - {1'b0, DrawX[9:3]}};
        bg = (stage_cur == START) ? BG_START :
             (stage_cur == WIN)   ? BG_WIN   :
             (stage_cur == LOSE)  ? BG_LOSE  :
             (DrawY >= PLAT_Y)    ? BG_PLATFORM : bat_rgb;
        // Walk from lowest to highest priority so layer 0 wins.
        lay = fit(bg);
        for (int i = NUM_LAYERS - 1; i >= 0; i--)
            if (layer_hit[i]) lay = layer_rgb[i*CW3 +: CW3];
        sel = (stage_cur == BATTLE) ? lay :
              text_hit              ? fit(TEXT_RGB) : fit(bg);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_rgb    <= '0;
            s1_valid  <= 1'b0;
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
            out_valid <= 1'b0;
        end else begin
            s1_rgb    <= sel;
            s1_valid  <= pix_valid;
            VGA_R     <= s2_rgb[2*COLOR_W +: COLOR_W];
            VGA_G     <= s2_rgb[COLOR_W +: COLOR_W];
            VGA_B     <= s2_rgb[0 +: COLOR_W];
            out_valid <= s1_valid;
        end
    end

endmodule

// File: tb/tb_layer_color_mapper.sv
// tb_layer_color_mapper: scoreboard bench; driver queues expected pixels, monitor checks them.
`timescale 1ns/1ps
module tb_layer_color_mapper;
    import cmap_pkg::*;

    localparam int NL = 3;
    localparam int CW = 8;

    logic             Clk = 1'b0;
    logic             Reset_n = 1'b1;
    logic             pix_valid = 1'b0;
    logic [9:0]       DrawX = '0;
    logic [9:0]       DrawY = '0;
    logic [NL-1:0]    layer_hit = '0;
    logic [NL*3*CW-1:0] layer_rgb = '0;
    logic             text_hit = 1'b0;
    stage_t           stage_req = START;
    logic             frame_start = 1'b0;
    logic [CW-1:0]    VGA_R, VGA_G, VGA_B;
    logic             out_valid, fade_busy;
    stage_t           stage_cur;

    int total = 0;
    int bad = 0;
    logic [23:0] sb[$];

    always #5 Clk = ~Clk;

    layer_color_mapper #(
        .NUM_LAYERS(NL), .COLOR_W(CW), .FADE_W(4), .PLATFORM_Y(380)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid),
        .DrawX(DrawX), .DrawY(DrawY), .layer_hit(layer_hit), .layer_rgb(layer_rgb),
        .text_hit(text_hit), .stage_req(stage_req), .frame_start(frame_start),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .out_valid(out_valid),
        .fade_busy(fade_busy), .stage_cur(stage_cur)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (Reset_n && out_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pixel: got %h%h%h want none", VGA_R, VGA_G, VGA_B);
            end else begin
                check("pixel", 32'({VGA_R, VGA_G, VGA_B}), 32'(sb.pop_front()));
            end
        end
    end

    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [2:0] lh,
                       input logic th, input logic [23:0] exp);
        @(posedge Clk); #1;
        pix_valid = 1'b1; DrawX = x; DrawY = y; layer_hit = lh; text_hit = th;
        sb.push_back(exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk); #1;
            pix_valid = 1'b0; layer_hit = '0; text_hit = 1'b0;
        end
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            idle(3);
            frame_start = 1'b1;
            @(posedge Clk); #1;
            frame_start = 1'b0;
        end
    endtask

    task automatic drain();
        idle(4);
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        layer_rgb = {24'h000000, 24'hFFFFFF, 24'hAAAAAA};
        #2 Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_stage", 32'(stage_cur), 32'(START));
        check("rst_busy", 32'(fade_busy), 32'd0);
        Reset_n = 1'b1;
        idle(2);

        pix(0, 0, 3'b000, 1'b0, 24'h0000FF);
        pix(5, 5, 3'b000, 1'b1, 24'h000000);
        pix(10, 10, 3'b001, 1'b0, 24'h0000FF);
        pix(10, 400, 3'b000, 1'b0, 24'h0000FF);
        drain();

        pix(1, 1, 3'b000, 1'b0, 24'h0000FF);
        @(posedge Clk); #1;
        pix_valid = 1'b0;
        check("lat_t1", 32'(out_valid), 32'd0);
        @(posedge Clk); #1;
        check("lat_t2", 32'(out_valid), 32'd1);
        @(posedge Clk); #1;
        check("lat_t3", 32'(out_valid), 32'd0);
        drain();

        stage_req = BATTLE;
`ifdef CMAP_FADE_EN
        @(posedge Clk); #1;
        check("busy_start", 32'(fade_busy), 32'd1);
        frames(32);
`else
        @(posedge Clk); #1;
        check("stage_hold", 32'(stage_cur), 32'(START));
        check("busy_nofade", 32'(fade_busy), 32'd0);
        frames(1);
`endif
        check("stage_battle", 32'(stage_cur), 32'(BATTLE));
        check("busy_battle", 32'(fade_busy), 32'd0);

        pix(0, 0, 3'b110, 1'b0, 24'hFFFFFF);
        pix(0, 0, 3'b100, 1'b0, 24'h000000);
        pix(0, 0, 3'b111, 1'b0, 24'hAAAAAA);
        pix(0, 400, 3'b000, 1'b0, 24'h00FF00);
        pix(0, 380, 3'b000, 1'b0, 24'h00FF00);
        pix(0, 379, 3'b000, 1'b0, 24'h3F007F);
        pix(80, 100, 3'b000, 1'b0, 24'h3F0075);
        pix(1023, 100, 3'b000, 1'b0, 24'h3F0000);
        pix(80, 100, 3'b000, 1'b1, 24'h3F0075);
        pix(15, 0, 3'b000, 1'b0, 24'h3F007E);
        drain();

        pix(0, 0, 3'b010, 1'b0, 24'hFFFFFF);
        pix(0, 0, 3'b010, 1'b0, 24'hFFFFFF);
        pix(0, 0, 3'b010, 1'b0, 24'hFFFFFF);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 Reset_n = 1'b0;
        stage_req = START;
        #1;
        check("arst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_stage", 32'(stage_cur), 32'(START));
        check("arst_busy", 32'(fade_busy), 32'd0);
        sb.delete();
        pix_valid = 1'b0;
        @(posedge Clk); #2;
        Reset_n = 1'b1;
        idle(2);

`ifdef CMAP_FADE_EN
        stage_req = WIN;
        frames(8);
        check("fade8_stage", 32'(stage_cur), 32'(START));
        check("fade8_busy", 32'(fade_busy), 32'd1);
        pix(0, 0, 3'b000, 1'b0, 24'h00007F);
        drain();
        frames(8);
        check("fade0_stage", 32'(stage_cur), 32'(WIN));
        pix(0, 0, 3'b000, 1'b0, 24'h000000);
        drain();
        frames(15);
        check("fadein15_busy", 32'(fade_busy), 32'd1);
        frames(1);
        check("fadein16_busy", 32'(fade_busy), 32'd0);
        pix(0, 0, 3'b000, 1'b0, 24'h9C1D08);
        drain();
        stage_req = LOSE;
        frames(21);
        check("lose_stage", 32'(stage_cur), 32'(LOSE));
        pix(0, 0, 3'b000, 1'b0, 24'h1B0027);
        drain();
        stage_req = START;
        frames(4);
        check("rev_stage", 32'(stage_cur), 32'(LOSE));
        pix(0, 0, 3'b000, 1'b0, 24'h050007);
        drain();
        frames(1);
        check("rev_swap", 32'(stage_cur), 32'(START));
        frames(15);
        check("rev_busy", 32'(fade_busy), 32'd1);
        frames(1);
        check("rev_done", 32'(fade_busy), 32'd0);
        pix(0, 0, 3'b000, 1'b0, 24'h0000FF);
        drain();
`else
        stage_req = WIN;
        frames(1);
        check("stage_win", 32'(stage_cur), 32'(WIN));
        pix(0, 0, 3'b000, 1'b0, 24'h9C1D08);
        pix(0, 0, 3'b000, 1'b1, 24'h000000);
        drain();
        stage_req = LOSE;
        frames(1);
        check("stage_lose", 32'(stage_cur), 32'(LOSE));
        check("busy_lose", 32'(fade_busy), 32'd0);
        pix(0, 0, 3'b000, 1'b0, 24'h57007F);
        pix(0, 400, 3'b011, 1'b0, 24'h57007F);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
